mem_wb_stage: RTL and testbench

MEM stage plus MEM/WB pipeline register for the 5-stage MIPS pipeline. It consumes the registered EX/MEM outputs and runs a req/ack transaction to data memory for lw/sw, with a variable number of wait states. While the access is pending it raises StallM to freeze the upstream stages. On completion it registers the writeback controls and data for the WB stage.

---
 rtl/mem_stage_pkg.sv | 13 +
 rtl/mem_timeout_ctr.sv | 36 +++
 rtl/mem_wb_stage.sv | 182 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the MEM stage and MEM/WB register
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam logic [1:0] WORD_ALIGN_MASK   = 2'b11;
  localparam logic       BUBBLE_REG_WRITE  = 1'b0;
  localparam logic       BUBBLE_MEM_TO_REG = 1'b0;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - wait-state counter; tc marks the MAX_WAIT-th wait cycle after the request
module mem_timeout_ctr #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The counter reads 0 in the first wait cycle, so MAX_WAIT wait cycles end at MAX_WAIT-1.
  assign tc = (cnt_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage req/ack data-memory access plus MEM/WB register
// Optional MEM_STALL_CNT_EN adds a saturating StallCount output.
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic        RegWriteM,
  input  logic [31:0] ALUResultAddrM,
  input  logic [31:0] DataWriteInM,
  input  logic [4:0]  RegisterDstM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [4:0]  RegisterDstW,
  output logic        MemErr
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [31:0] StallCount
`endif
);

  mem_state_e  state_q, state_d;
  logic        reg_write_w_q, reg_write_w_d;
  logic        mem_to_reg_w_q, mem_to_reg_w_d;
  logic [31:0] read_data_w_q, read_data_w_d;
  logic [31:0] alu_result_w_q, alu_result_w_d;
  logic [4:0]  register_dst_w_q, register_dst_w_d;
  logic        mem_err_q, mem_err_d;

  logic access, conflict, misaligned;
  logic do_load, do_bubble, err_set, ctr_clr, ctr_en, ctr_tc;

  assign access     = MemReadM ^ MemWriteM;
  assign conflict   = MemReadM & MemWriteM;
  assign misaligned = |(ALUResultAddrM[1:0] & WORD_ALIGN_MASK);

  mem_timeout_ctr #(
    .MAX_WAIT(MAX_WAIT),
    .WAIT_W  (WAIT_W)
  ) u_timeout (
    .clk  (clk),
    .reset(reset),
    .clr  (ctr_clr),
    .en   (ctr_en),
    .tc   (ctr_tc)
  );

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    StallM    = 1'b0;
    do_load   = 1'b0;
    do_bubble = 1'b0;
    err_set   = 1'b0;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (conflict || (access && misaligned)) begin
          err_set   = 1'b1;
          do_bubble = 1'b1;
        end else if (access) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            do_load = 1'b1;
          end else begin
            StallM    = 1'b1;
            do_bubble = 1'b1;
            ctr_clr   = 1'b1;
            state_d   = WAIT;
          end
        end else begin
          do_load = 1'b1;
        end
      end
      WAIT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          do_load = 1'b1;
          state_d = IDLE;
        end else if (ctr_tc) begin
          err_set   = 1'b1;
          do_bubble = 1'b1;
          state_d   = IDLE;
        end else begin
          ctr_en    = 1'b1;
          StallM    = 1'b1;
          do_bubble = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    reg_write_w_d    = reg_write_w_q;
    mem_to_reg_w_d   = mem_to_reg_w_q;
    read_data_w_d    = read_data_w_q;
    alu_result_w_d   = alu_result_w_q;
    register_dst_w_d = register_dst_w_q;
    mem_err_d        = mem_err_q | err_set;
    if (do_load) begin
      reg_write_w_d    = RegWriteM;
      mem_to_reg_w_d   = MemtoRegM;
      alu_result_w_d   = ALUResultAddrM;
      register_dst_w_d = RegisterDstM;
      if (MemReadM) begin
        read_data_w_d = mem_rdata;
      end
    end else if (do_bubble) begin
      reg_write_w_d  = BUBBLE_REG_WRITE;
      mem_to_reg_w_d = BUBBLE_MEM_TO_REG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      reg_write_w_q    <= 1'b0;
      mem_to_reg_w_q   <= 1'b0;
      read_data_w_q    <= '0;
      alu_result_w_q   <= '0;
      register_dst_w_q <= '0;
      mem_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      reg_write_w_q    <= reg_write_w_d;
      mem_to_reg_w_q   <= mem_to_reg_w_d;
      read_data_w_q    <= read_data_w_d;
      alu_result_w_q   <= alu_result_w_d;
      register_dst_w_q <= register_dst_w_d;
      mem_err_q        <= mem_err_d;
    end
  end

  assign mem_we       = mem_req & MemWriteM;
  assign mem_addr     = ALUResultAddrM;
  assign mem_wdata    = DataWriteInM;
  assign RegWriteW    = reg_write_w_q;
  assign MemtoRegW    = mem_to_reg_w_q;
  assign ReadDataW    = read_data_w_q;
  assign ALUResultW   = alu_result_w_q;
  assign RegisterDstW = register_dst_w_q;
  assign MemErr       = mem_err_q;

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (StallM && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign StallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized self-checking bench for mem_wb_stage against a transaction-level model
module tb_mem_wb_stage;

  localparam int MAX_WAIT = 15;
  localparam int NO_ACK   = 99;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM, MemtoRegM, RegWriteM;
  logic [31:0] ALUResultAddrM, DataWriteInM;
  logic [4:0]  RegisterDstM;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        StallM, RegWriteW, MemtoRegW, MemErr;
  logic [31:0] ReadDataW, ALUResultW;
  logic [4:0]  RegisterDstW;
`ifdef MEM_STALL_CNT_EN
  logic [31:0] StallCount;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] exp_read_data;
  logic        exp_err;
  longint      exp_stall_total;

  always #5 clk = ~clk;

  mem_wb_stage #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .MemReadM      (MemReadM),
    .MemWriteM     (MemWriteM),
    .MemtoRegM     (MemtoRegM),
    .RegWriteM     (RegWriteM),
    .ALUResultAddrM(ALUResultAddrM),
    .DataWriteInM  (DataWriteInM),
    .RegisterDstM  (RegisterDstM),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .StallM        (StallM),
    .RegWriteW     (RegWriteW),
    .MemtoRegW     (MemtoRegW),
    .ReadDataW     (ReadDataW),
    .ALUResultW    (ALUResultW),
    .RegisterDstW  (RegisterDstW),
    .MemErr        (MemErr)
`ifdef MEM_STALL_CNT_EN
    ,
    .StallCount    (StallCount)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a * 32'h9E37_79B1;
  endfunction

  task automatic clear_inputs();
    MemReadM = 0; MemWriteM = 0; MemtoRegM = 0; RegWriteM = 0;
    ALUResultAddrM = 0; DataWriteInM = 0; RegisterDstM = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rw"}, RegWriteW, 0);
    check({tag, "_mtr"}, MemtoRegW, 0);
    check({tag, "_rd"}, ReadDataW, 0);
    check({tag, "_alu"}, ALUResultW, 0);
    check({tag, "_dst"}, RegisterDstW, 0);
    check({tag, "_err"}, MemErr, 0);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_stall"}, StallM, 0);
`ifdef MEM_STALL_CNT_EN
    check({tag, "_scnt"}, StallCount, 0);
`endif
  endtask

  task automatic model_reset();
    exp_read_data   = 0;
    exp_err         = 0;
    exp_stall_total = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    check_reset_state("rst");
    reset = 0;
    model_reset();
  endtask

  // One instruction sits in EX/MEM until StallM releases it; lat is the cycle (0 = request cycle) the memory acks in.
  task automatic run_instr(input logic rd, input logic wr, input logic mtr, input logic rw,
                           input logic [31:0] addr, input logic [31:0] data, input logic [4:0] dst,
                           input int lat);
    logic bad_inst, valid, timed_out, complete, seen_req, st;
    logic [31:0] mval;
    int stalls, cyc, exp_stalls;
    bad_inst  = (rd & wr) || ((rd ^ wr) && (addr[1:0] != 2'b00));
    valid     = (rd ^ wr) && (addr[1:0] == 2'b00);
    timed_out = valid && (lat > MAX_WAIT);
    complete  = !bad_inst && !timed_out;
    mval      = mem_read(addr);
    MemReadM = rd; MemWriteM = wr; MemtoRegM = mtr; RegWriteM = rw;
    ALUResultAddrM = addr; DataWriteInM = data; RegisterDstM = dst;
    stalls = 0; cyc = 0; seen_req = 0; st = 1;
    while (st && cyc < 40) begin
      #1;
      if (valid) mem_ack = mem_req && (cyc == lat);
      else       mem_ack = ($urandom_range(0, 1) == 1);
      mem_rdata = mem_ack ? mval : $urandom;
      #1;
      if (mem_req) begin
        seen_req = 1;
        check("req_we", mem_we, wr);
        check("req_addr", mem_addr, addr);
        check("req_wdata", mem_wdata, data);
      end
      st = StallM;
      if (st) stalls++;
      @(posedge clk); #1;
      cyc++;
    end
    mem_ack = 0;
    check("stall_release", st, 0);
    exp_stalls = !valid ? 0 : (lat < MAX_WAIT ? lat : MAX_WAIT);
    check("stall_cycles", stalls, exp_stalls);
    check("req_seen", seen_req, valid);
    exp_stall_total += exp_stalls;
    if (!complete) exp_err = 1;
    if (complete) begin
      if (wr) mem_model[addr] = data;
      if (rd) exp_read_data = mval;
      check("wb_rw", RegWriteW, rw);
      check("wb_mtr", MemtoRegW, mtr);
      check("wb_alu", ALUResultW, addr);
      check("wb_dst", RegisterDstW, dst);
      check("wb_rdata", ReadDataW, exp_read_data);
    end else begin
      check("bubble_rw", RegWriteW, 0);
      check("bubble_mtr", MemtoRegW, 0);
    end
    check("mem_err", MemErr, exp_err);
`ifdef MEM_STALL_CNT_EN
    check("stall_count", StallCount, exp_stall_total[31:0]);
`endif
  endtask

  initial begin
    int kind, lat;
    logic [31:0] a;
    clear_inputs();
    model_reset();
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    check_reset_state("init");
    reset = 0;

    run_instr(0, 0, 0, 1, 32'h10, 32'h0, 5'd5, 0);
    run_instr(1, 0, 1, 1, 32'h40, 32'h0, 5'd8, 0);
    mem_model[32'h40] = 32'hDEAD_BEEF;
    run_instr(1, 0, 1, 1, 32'h40, 32'h0, 5'd9, 0);
    check("lw_deadbeef", ReadDataW, 32'hDEAD_BEEF);
    run_instr(0, 1, 0, 0, 32'h44, 32'h1234, 5'd0, 3);
    run_instr(1, 0, 1, 1, 32'h44, 32'h0, 5'd3, MAX_WAIT);
    run_instr(1, 0, 1, 1, 32'h80, 32'h0, 5'd4, NO_ACK);
    run_instr(0, 0, 0, 1, 32'h77, 32'h0, 5'd6, 0);
    do_reset();
    run_instr(1, 0, 1, 1, 32'h42, 32'h0, 5'd7, 0);
    do_reset();
    run_instr(1, 1, 0, 1, 32'h48, 32'h55, 5'd2, 0);
    do_reset();

    MemReadM = 1; MemtoRegM = 1; RegWriteM = 1; ALUResultAddrM = 32'h80; RegisterDstM = 5'd9;
    #2;
    check("rstw_req0", mem_req, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstw_stall", StallM, 1);
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    check_reset_state("rstw");
    reset = 0;
    model_reset();

    for (int i = 0; i < 160; i++) begin
      if (i % 40 == 39) do_reset();
      kind = $urandom_range(0, 5);
      a    = {24'h0, $urandom_range(0, 31) * 4};
      lat  = ($urandom_range(0, 9) == 0) ? NO_ACK : $urandom_range(0, 6);
      if ($urandom_range(0, 15) == 0) lat = MAX_WAIT;
      case (kind)
        0, 1: run_instr(0, 0, 0, $urandom_range(0, 1), $urandom, 0, $urandom_range(0, 31), 0);
        2:    run_instr(1, 0, 1, 1, a, 0, $urandom_range(0, 31), lat);
        3:    run_instr(0, 1, 0, 0, a, $urandom, 0, lat);
        4:    run_instr(1, 0, 1, 1, a | $urandom_range(1, 3), 0, 5'd1, lat);
        default: run_instr(1, 1, 0, 1, a, $urandom, 5'd2, lat);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
